uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-granular, round-robin arbiter sharing one 8N1 UART transmit line between two byte-stream requesters: the Nios-side software FIFO (port 0) and the hardware bridge path (port 1). It sits in front of the `bt_uart` or `wifi_uart` TXD pin in the TAG system. Once a requester is granted, it keeps the line until it delivers a byte flagged `last` or goes silent past a timeout. Requesters never interleave bytes within a packet.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: `clk_clk` cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `IDLE_TIMEOUT`, default 65535: owner-silent cycles before a lock is forcibly released; legal range ≥ 1.

**Ports**
- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset_n`  in  1  reset, synchronous, active-low.
- `req0_data`  in  8  port-0 byte.
- `req0_valid`  in  1  port-0 byte available.
- `req0_last`  in  1  port-0 byte ends its packet.
- `req0_ready`  out  1  port-0 byte accepted this cycle when `valid` is also high.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same as port 0, for port 1.
- `uart_TXD`  out  1  serial output; idles high.
- `grant`  out  2  one-hot current owner; 00 when unlocked.
- `busy`  out  1  serializer is shifting a frame.
- `timeout_pulse`  out  1  one-cycle pulse when a lock is released by timeout.

## Operation

- **Arbiter FSM states:** ARB_IDLE, ARB_LOCK.
- **ARB_IDLE:**
  - If exactly one `reqN_valid` is high, lock that port.
  - If both are high, lock the port that is not `last_served`.
  - `last_served` resets to 1, so port 0 wins the first tie after reset.
  - The transition to ARB_LOCK occurs on the clock edge; `grant` updates the same edge.
- **ARB_LOCK, owner N:**
  - `reqN_ready` = owner granted AND serializer idle.
  - `ready` is a function of registers only; there is no combinational path from `valid`.
  - A byte is accepted on `valid && ready`.
  - Accepting a byte with `last`=1 returns the FSM to ARB_IDLE, sets `last_served`=N, and clears `grant`.
- **Non-owner:** `ready` is always 0.
- **Timeout:**
  - The idle counter increments each cycle in ARB_LOCK while the serializer is idle and the owner's `valid` is 0.
  - The counter clears on accept and on entry to ARB_LOCK.
  - When the count reaches IDLE_TIMEOUT: go to ARB_IDLE, set `last_served`=owner, and pulse `timeout_pulse` for one cycle.
- **Serializer FSM states:** SER_IDLE, SER_START, SER_DATA, SER_STOP.
  - Frame is 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The byte is latched on accept.
  - `busy` is high in all states except SER_IDLE.
- **Re-arbitration:** may occur while the final byte of a packet is still shifting. The new owner's `ready` waits for SER_IDLE.
- **Width rules:**
  - Baud counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - Idle counter is $clog2(IDLE_TIMEOUT+1) bits and saturates.

## Timing

- **Reset values:** `uart_TXD`=1, `grant`=00, `busy`=0, `req0_ready`=0, `req1_ready`=0, `timeout_pulse`=0, `last_served`=1, both FSMs in their IDLE states.
- **Reset mid-frame:** `uart_TXD` returns high at the reset edge; the byte in flight is dropped; the lock is cleared.
- **Grant latency:** `valid` high at cycle t in ARB_IDLE → `grant` set at t+1 → `ready` high at t+1 if the serializer is idle.
- **Frame latency:** accept at cycle t → start bit on `uart_TXD` from t+1 through t+CLKS_PER_BIT → stop bit ends at t+10·CLKS_PER_BIT → `ready` high again at t+10·CLKS_PER_BIT+1.
- **Throughput:** minimum byte period is 10·CLKS_PER_BIT+1 cycles.
- **Timeout vs. arrival:** if `valid` rises on the same cycle the timeout fires, the timeout wins. The byte is not accepted and competes in ARB_IDLE next cycle.
- **Lock persistence:** `valid` dropping mid-packet does not release the lock before the timeout.

## Structure

- Package `tag_uart_pkg`:
  - `arb_state_t`, `ser_state_t` enums.
  - Constants FRAME_BITS=10, DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module `uart_tx_serializer`:
  - Ports: `clk_clk`, `reset_reset_n`, `load`, `din[7:0]`, `tx`, `idle`; parameter CLKS_PER_BIT.
  - It holds the baud counter, bit index and shift register.
- The top level holds the arbiter FSM, the idle counter, `last_served` and the output muxing.

## Test plan

- **Single byte:** CLKS_PER_BIT=4; port 0 sends 0xA5 with `last`.
  - `grant`=01 one cycle after `valid`.
  - `uart_TXD` shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `grant`=00 after accept; next `ready` 41 cycles after accept.
- **Tie at reset:** both ports `valid` on the first cycle after reset.
  - Port 0 is granted.
  - After port 0's `last` byte, port 1 is granted, even though port 0 is still valid.
- **Packet atomicity:** port 0 sends 3 bytes (`last` on the 3rd) while port 1 holds `valid` throughout.
  - `req1_ready` stays 0 until the 3rd byte is accepted.
  - No port-1 byte appears between port-0 bytes.
- **Timeout:** IDLE_TIMEOUT=8; port 1 sends one non-last byte, then deasserts `valid`.
  - `timeout_pulse` fires 8 idle cycles after the frame ends.
  - `grant`=00, and port 0 is granted next.
- **Reset mid-frame:** assert `reset_reset_n`=0 during data bit 3.
  - `uart_TXD`=1, `busy`=0 and `grant`=00 at the next edge.
  - After release, a fresh byte transmits correctly.

Source files
------------

// File: rtl/tag_uart_pkg.sv
// Shared types and framing constants for the TAG UART transmit path.
package tag_uart_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake for the two requesters sharing the UART transmit line.
interface uart_tx_arbiter_if;

    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;

    modport master (
        output req0_data, req0_valid, req0_last,
        input  req0_ready,
        output req1_data, req1_valid, req1_last,
        input  req1_ready
    );

    modport slave (
        input  req0_data, req0_valid, req0_last,
        output req0_ready,
        input  req1_data, req1_valid, req1_last,
        output req1_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: latches a byte on load and shifts start, data (LSB first), stop.
module uart_tx_serializer
    import tag_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       tx,
    output logic       idle
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    ser_state_t        state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              bit_done;

    assign bit_done = (baud_reg == BAUD_LAST);
    assign tx       = tx_reg;
    assign idle     = (state_reg == SER_IDLE);

    // tx_reg is loaded one bit ahead so each bit appears exactly at its period boundary
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg   <= SER_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= STOP_BIT;
        end else begin
            case (state_reg)
                SER_IDLE: begin
                    if (load) begin
                        shift_reg <= din;
                        tx_reg    <= START_BIT;
                        baud_reg  <= '0;
                        state_reg <= SER_START;
                    end
                end
                SER_START: begin
                    if (bit_done) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state_reg   <= SER_DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                SER_DATA: begin
                    if (bit_done) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == BIT_LAST) begin
                            tx_reg    <= STOP_BIT;
                            state_reg <= SER_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                SER_STOP: begin
                    if (bit_done) begin
                        baud_reg  <= '0;
                        state_reg <= SER_IDLE;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: state_reg <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit line between two byte streams.
module uart_tx_arbiter
    import tag_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    uart_tx_arbiter_if.slave         req,
    output logic                     uart_TXD,
    output logic [1:0]               grant,
    output logic                     busy,
    output logic                     timeout_pulse
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);

    arb_state_t        arb_state_reg, arb_state_next;
    logic              owner_reg, owner_next;
    logic              last_served_reg, last_served_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;

    logic       ser_idle;
    logic       locked;
    logic       timed_out;
    logic       owner_open;
    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_data;
    logic       accept;

    assign locked    = (arb_state_reg == ARB_LOCK);
    assign timed_out = locked && (idle_cnt_reg == IDLE_LIMIT);
    // Owner may hand over a byte; built from registers only, and closed on the timeout cycle
    assign owner_open = locked && ser_idle && !timed_out;

    assign owner_valid = owner_reg ? req.req1_valid : req.req0_valid;
    assign owner_last  = owner_reg ? req.req1_last  : req.req0_last;
    assign owner_data  = owner_reg ? req.req1_data  : req.req0_data;
    assign accept      = owner_open && owner_valid;

    assign req.req0_ready = owner_open && !owner_reg;
    assign req.req1_ready = owner_open &&  owner_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = locked && (owner_reg == 1'(gi));
        end
    endgenerate

    assign busy          = !ser_idle;
    assign timeout_pulse = timed_out;

    always_comb begin
        arb_state_next   = arb_state_reg;
        owner_next       = owner_reg;
        last_served_next = last_served_reg;
        idle_cnt_next    = idle_cnt_reg;
        case (arb_state_reg)
            ARB_IDLE: begin
                if (req.req0_valid || req.req1_valid) begin
                    arb_state_next = ARB_LOCK;
                    owner_next     = (req.req0_valid && req.req1_valid) ? !last_served_reg
                                                                         : req.req1_valid;
                    idle_cnt_next  = '0;
                end
            end
            ARB_LOCK: begin
                if (timed_out) begin
                    arb_state_next   = ARB_IDLE;
                    last_served_next = owner_reg;
                end else if (accept) begin
                    idle_cnt_next = '0;
                    if (owner_last) begin
                        arb_state_next   = ARB_IDLE;
                        last_served_next = owner_reg;
                    end
                end else if (ser_idle && !owner_valid && (idle_cnt_reg != IDLE_LIMIT)) begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            default: arb_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            arb_state_reg   <= ARB_IDLE;
            owner_reg       <= 1'b0;
            last_served_reg <= 1'b1;
            idle_cnt_reg    <= '0;
        end else begin
            arb_state_reg   <= arb_state_next;
            owner_reg       <= owner_next;
            last_served_reg <= last_served_next;
            idle_cnt_reg    <= idle_cnt_next;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .load          (accept),
        .din           (owner_data),
        .tx            (uart_TXD),
        .idle          (ser_idle)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-sequence bench with random payloads; a behavioural UART receiver decodes the line.
module tb_uart_tx_arbiter;
    import tag_uart_pkg::*;

    localparam int C  = 4;
    localparam int IT = 8;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       uart_TXD;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk_clk = ~clk_clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .CLKS_PER_BIT (C),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req           (bus),
        .uart_TXD      (uart_TXD),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    // Expected line level for bit k of an 8N1 frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return START_BIT;
        if (k == FRAME_BITS - 1) return STOP_BIT;
        return d[k-1];
    endfunction

    // Holds the current request until accepted; returns at the negedge after the accept edge
    task automatic wait_accept(input int p, output int waited, output bit other_rdy);
        waited = 0;
        other_rdy = 1'b0;
        while (!rdy(p) && waited < 2000) begin
            if (rdy(1 - p)) other_rdy = 1'b1;
            @(negedge clk_clk);
            waited++;
        end
        if (!rdy(p)) begin
            chk("accept_budget", 32'(rdy(p)), 32'd1);
        end else begin
            if (rdy(1 - p)) other_rdy = 1'b1;
            @(negedge clk_clk);
        end
    endtask

    // Behavioural receiver sampling mid-bit; frames overlapping a reset are discarded
    logic [9:0] rx_frame;
    bit         rx_abort;
    always begin
        @(negedge clk_clk);
        if (reset_reset_n === 1'b1 && uart_TXD === 1'b0) begin
            rx_abort = 1'b0;
            rx_frame = '0;
            for (int n = 0; n < 9 * C + C / 2; n++) begin
                if (reset_reset_n !== 1'b1) rx_abort = 1'b1;
                if (n % C == C / 2) rx_frame[n / C] = uart_TXD;
                @(negedge clk_clk);
            end
            if (reset_reset_n !== 1'b1) rx_abort = 1'b1;
            rx_frame[9] = uart_TXD;
            if (!rx_abort) begin
                chk("rx_start", 32'(rx_frame[0]), 32'(START_BIT));
                chk("rx_stop", 32'(rx_frame[9]), 32'(STOP_BIT));
                rx_q.push_back(rx_frame[8:1]);
            end
        end
    end

    initial begin
        int waited;
        bit other;
        bit leak;
        logic [7:0] b0, b1, b2, q, r, s, u, m, f;
        logic [7:0] p[3];

        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk_clk);
        chk("rst_txd", 32'(uart_TXD), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst_tpulse", 32'(timeout_pulse), 32'd0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Single byte 0xA5 with last, bit-by-bit line check
        set_req(0, 1'b1, 8'hA5, 1'b1);
        @(negedge clk_clk);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk_clk);
        set_req(0, 1'b0, 8'h00, 1'b0);
        exp_q.push_back(8'hA5);
        chk("t1_grant_clr", 32'(grant), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int j = 0; j < C; j++) begin
                chk($sformatf("t1_txd_b%0d", k), 32'(uart_TXD), 32'(frame_bit(8'hA5, k)));
                @(negedge clk_clk);
            end
        end
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Tie straight after reset: port 0 first, then port 1 despite port 0 still valid
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        set_req(0, 1'b1, b0, 1'b1);
        set_req(1, 1'b1, b1, 1'b1);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        chk("t2_grant_tie", 32'(grant), 32'd1);
        wait_accept(0, waited, other);
        exp_q.push_back(b0);
        set_req(0, 1'b1, b2, 1'b1);
        chk("t2_grant_gap", 32'(grant), 32'd0);
        @(negedge clk_clk);
        chk("t2_grant_rr", 32'(grant), 32'd2);
        wait_accept(1, waited, other);
        exp_q.push_back(b1);
        set_req(1, 1'b0, 8'h00, 1'b0);
        chk("t2_r1_wait", 32'(waited), 32'(10 * C - 1));
        chk("t2_grant_gap2", 32'(grant), 32'd0);
        @(negedge clk_clk);
        chk("t2_grant_back", 32'(grant), 32'd1);
        wait_accept(0, waited, other);
        exp_q.push_back(b2);
        set_req(0, 1'b0, 8'h00, 1'b0);

        // Packet atomicity: three port-0 bytes while port 1 waits
        for (int i = 0; i < 3; i++) p[i] = 8'($urandom);
        q = 8'($urandom);
        leak = 1'b0;
        set_req(0, 1'b1, p[0], 1'b0);
        @(negedge clk_clk);
        chk("t3_grant", 32'(grant), 32'd1);
        set_req(1, 1'b1, q, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, p[i], (i == 2));
            wait_accept(0, waited, other);
            leak = leak | other;
            exp_q.push_back(p[i]);
            if (i == 1) chk("t3_byte_period", 32'(waited), 32'(10 * C));
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        chk("t3_r1_leak", 32'(leak), 32'd0);
        chk("t3_grant_gap", 32'(grant), 32'd0);
        @(negedge clk_clk);
        chk("t3_grant_p1", 32'(grant), 32'd2);
        wait_accept(1, waited, other);
        exp_q.push_back(q);
        set_req(1, 1'b0, 8'h00, 1'b0);

        // Timeout: port 1 goes silent mid-packet; arrivals on the timeout cycle are refused
        r = 8'($urandom); s = 8'($urandom); u = 8'($urandom);
        set_req(1, 1'b1, r, 1'b0);
        wait_accept(1, waited, other);
        exp_q.push_back(r);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (10 * C + IT - 1) @(negedge clk_clk);
        chk("t4_tpulse_early", 32'(timeout_pulse), 32'd0);
        chk("t4_grant_held", 32'(grant), 32'd2);
        @(negedge clk_clk);
        chk("t4_tpulse", 32'(timeout_pulse), 32'd1);
        chk("t4_ready1_blocked", 32'(bus.req1_ready), 32'd0);
        set_req(1, 1'b1, s, 1'b1);
        set_req(0, 1'b1, u, 1'b1);
        @(negedge clk_clk);
        chk("t4_tpulse_once", 32'(timeout_pulse), 32'd0);
        chk("t4_grant_clr", 32'(grant), 32'd0);
        @(negedge clk_clk);
        chk("t4_grant_p0", 32'(grant), 32'd1);
        wait_accept(0, waited, other);
        exp_q.push_back(u);
        set_req(0, 1'b0, 8'h00, 1'b0);
        chk("t4_grant_gap", 32'(grant), 32'd0);
        @(negedge clk_clk);
        chk("t4_grant_p1", 32'(grant), 32'd2);
        wait_accept(1, waited, other);
        exp_q.push_back(s);
        set_req(1, 1'b0, 8'h00, 1'b0);

        // Reset during data bit 3 (bit 3 forced to 0 so the line change is visible)
        repeat (10 * C + 2) @(negedge clk_clk);
        m = 8'($urandom) & 8'hF7;
        set_req(0, 1'b1, m, 1'b0);
        wait_accept(0, waited, other);
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (4 * C + 1) @(negedge clk_clk);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("t5_txd", 32'(uart_TXD), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (40) @(negedge clk_clk);
        f = 8'($urandom);
        set_req(1, 1'b1, f, 1'b1);
        wait_accept(1, waited, other);
        exp_q.push_back(f);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (12 * C) @(negedge clk_clk);

        chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
